// File: rtl/timer_pkg.sv
// Shared register map and bit positions for the mmio_timer block.
package timer_pkg;

  localparam logic [3:0] ADDR_CTRL     = 4'd0;
  localparam logic [3:0] ADDR_PRESCALE = 4'd1;
  localparam logic [3:0] ADDR_LOAD     = 4'd2;
  localparam logic [3:0] ADDR_COUNT    = 4'd3;
  localparam logic [3:0] ADDR_STATUS   = 4'd4;
  localparam logic [3:0] ADDR_COMPARE  = 4'd5;

  localparam int CTRL_ENABLE_BIT      = 0;
  localparam int CTRL_AUTO_RELOAD_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT      = 2;

  localparam int STATUS_EXPIRED_BIT   = 0;

  typedef struct packed {
    logic irq_en;
    logic auto_reload;
    logic enable;
  } ctrl_t;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for mmio_timer: counts 0..limit while enabled and pulses tick on the wrap.
// A clear restarts the count at 0 and suppresses any tick in that cycle.
module timer_prescaler #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         enable,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic         tick
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == limit) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer with prescaler, auto-reload and level interrupt.
// Defining TIMER_PWM_EN adds the COMPARE register and a registered PWM output.
module mmio_timer
  import timer_pkg::*;
#(
  parameter int PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        en,
  input  logic        wen,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        pwm
);

  ctrl_t                 ctrl_q, ctrl_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [31:0]           load_q, load_d;
  logic [31:0]           count_q, count_d;
  logic                  expired_q, expired_d;

  logic wr_en, rd_en;
  logic wr_ctrl, wr_prescale, wr_load, wr_count, wr_status;
  logic psc_clear, tick, expire;
  logic [31:0] compare_rd;

  // Bus: en selects the block; en&wen is a one-cycle write committed on the next
  // clk edge, en&~wen is a combinational read, and rdata is 0 whenever not reading.
  assign wr_en       = en & wen;
  assign rd_en       = en & ~wen;
  assign wr_ctrl     = wr_en & (addr == ADDR_CTRL);
  assign wr_prescale = wr_en & (addr == ADDR_PRESCALE);
  assign wr_load     = wr_en & (addr == ADDR_LOAD);
  assign wr_count    = wr_en & (addr == ADDR_COUNT);
  assign wr_status   = wr_en & (addr == ADDR_STATUS);

  // A COUNT write or an enable 0->1 transition restarts the prescale period.
  assign psc_clear = wr_count | (wr_ctrl & wdata[CTRL_ENABLE_BIT] & ~ctrl_q.enable);

  timer_prescaler #(
    .W(PRESCALE_W)
  ) u_prescaler (
    .clk    (clk),
    .nreset (nreset),
    .enable (ctrl_q.enable),
    .clear  (psc_clear),
    .limit  (prescale_q),
    .tick   (tick)
  );

  assign expire = tick & (count_q == '0);

  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    load_d     = load_q;
    count_d    = count_q;
    expired_d  = expired_q;

    if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - 32'd1;
      end else if (ctrl_q.auto_reload) begin
        count_d = load_q;
      end else begin
        ctrl_d.enable = 1'b0;
      end
    end

    // Expiry outranks a simultaneous W1C so an event is never lost.
    if (expire) begin
      expired_d = 1'b1;
    end else if (wr_status && wdata[STATUS_EXPIRED_BIT]) begin
      expired_d = 1'b0;
    end

    if (wr_ctrl) begin
      ctrl_d.enable      = wdata[CTRL_ENABLE_BIT];
      ctrl_d.auto_reload = wdata[CTRL_AUTO_RELOAD_BIT];
      ctrl_d.irq_en      = wdata[CTRL_IRQ_EN_BIT];
    end
    if (wr_prescale) prescale_d = wdata[PRESCALE_W-1:0];
    if (wr_load)     load_d     = wdata;
    if (wr_count)    count_d    = wdata;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      load_q     <= '0;
      count_q    <= '0;
      expired_q  <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      load_q     <= load_d;
      count_q    <= count_d;
      expired_q  <= expired_d;
    end
  end

  assign irq = expired_q & ctrl_q.irq_en;

`ifdef TIMER_PWM_EN
  logic [31:0] compare_q, compare_d;
  logic        pwm_q, pwm_d;

  always_comb begin
    compare_d = compare_q;
    if (wr_en && (addr == ADDR_COMPARE)) compare_d = wdata;
    pwm_d = (count_q < compare_q) & ctrl_q.enable;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      compare_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      compare_q <= compare_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm        = pwm_q;
  assign compare_rd = compare_q;
`else
  assign pwm        = 1'b0;
  assign compare_rd = '0;
`endif

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (addr)
        ADDR_CTRL: begin
          rdata[CTRL_ENABLE_BIT]      = ctrl_q.enable;
          rdata[CTRL_AUTO_RELOAD_BIT] = ctrl_q.auto_reload;
          rdata[CTRL_IRQ_EN_BIT]      = ctrl_q.irq_en;
        end
        ADDR_PRESCALE: rdata[PRESCALE_W-1:0]     = prescale_q;
        ADDR_LOAD:     rdata                     = load_q;
        ADDR_COUNT:    rdata                     = count_q;
        ADDR_STATUS:   rdata[STATUS_EXPIRED_BIT] = expired_q;
        ADDR_COMPARE:  rdata                     = compare_rd;
        default:       rdata                     = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Scoreboard bench for mmio_timer: directed scenarios plus random register traffic
// checked against a behavioural model. Build with +define+TIMER_PWM_EN for the PWM build.
module tb_mmio_timer;

  localparam int PW = 16;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        en = 1'b0;
  logic        wen = 1'b0;
  logic [3:0]  addr = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;
  logic        pwm;

  mmio_timer #(.PRESCALE_W(PW)) dut (
    .clk    (clk),
    .nreset (nreset),
    .en     (en),
    .wen    (wen),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq),
    .pwm    (pwm)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Timer seen as: a tick every (PRESCALE+1) enabled cycles counted from the last
  // prescaler restart; each tick decrements COUNT or, at zero, expires.
  bit          m_en, m_auto, m_irqen, m_exp, m_pwm;
  int unsigned m_pre, m_load, m_count, m_cmp, m_elapsed;
  bit          t_tick, t_cnt_wr, t_en_rise, t_expire;

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a)
      4'd0: return {29'd0, m_irqen, m_auto, m_en};
      4'd1: return m_pre;
      4'd2: return m_load;
      4'd3: return m_count;
      4'd4: return {31'd0, m_exp};
`ifdef TIMER_PWM_EN
      4'd5: return m_cmp;
`endif
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_en = 0; m_auto = 0; m_irqen = 0; m_exp = 0; m_pwm = 0;
      m_pre = 0; m_load = 0; m_count = 0; m_cmp = 0; m_elapsed = 0;
    end else begin
      t_cnt_wr  = en && wen && (addr == 4'd3);
      t_en_rise = en && wen && (addr == 4'd0) && wdata[0] && !m_en;
      t_tick    = m_en && ((m_elapsed % (m_pre + 1)) == m_pre) && !t_cnt_wr;
      t_expire  = t_tick && (m_count == 0);
`ifdef TIMER_PWM_EN
      m_pwm = (m_count < m_cmp) && m_en;
`endif
      if (t_cnt_wr || t_en_rise) m_elapsed = 0;
      else if (m_en) m_elapsed++;
      if (t_tick) begin
        if (m_count > 0) m_count--;
        else if (m_auto) m_count = m_load;
        else m_en = 0;
      end
      if (t_expire) m_exp = 1;
      else if (en && wen && addr == 4'd4 && wdata[0]) m_exp = 0;
      if (en && wen) begin
        case (addr)
          4'd0: {m_irqen, m_auto, m_en} = wdata[2:0];
          4'd1: m_pre = wdata & ((32'd1 << PW) - 32'd1);
          4'd2: m_load = wdata;
          4'd3: m_count = wdata;
`ifdef TIMER_PWM_EN
          4'd5: m_cmp = wdata;
`endif
          default: ;
        endcase
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (en && !wen) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rdata_unexpected: got %0h expected no read at t=%0t", rdata, $time);
      end else begin
        check($sformatf("rdata[a=%0d]", addr), rdata, exp_q.pop_front());
      end
    end else begin
      check("rdata_idle", rdata, 32'd0);
    end
    check("irq", 32'(irq), 32'(m_exp & m_irqen));
    check("pwm", 32'(pwm), 32'(m_pwm));
  end

  // ---------------- driver tasks ----------------
  task automatic bus(input logic e, input logic w, input logic [3:0] a, input logic [31:0] d);
    en = e; wen = w; addr = a; wdata = d;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    bus(1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic rd_m(input logic [3:0] a);
    rd(a, model_read(a));
  endtask

  task automatic idle(input int n);
    repeat (n) bus(1'b0, 1'b0, 4'd0, 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int hi;
    nreset = 1'b0;
    repeat (3) @(posedge clk);
    #1 nreset = 1'b1;

    // Reset values of the whole map.
    for (int a = 0; a < 6; a++) rd(4'(a), 32'd0);

    // One-shot: PRESCALE=3, COUNT=2 expires 12 cycles after enable.
    wr(4'd1, 32'd3); wr(4'd2, 32'd2); wr(4'd3, 32'd2); wr(4'd0, 32'd5);
    idle(11);
    rd(4'd4, 32'd0);
    rd(4'd4, 32'd1);
    rd(4'd0, 32'd4);
    rd(4'd3, 32'd0);
    check("irq_after_oneshot", 32'(irq), 32'd1);

    // Auto-reload with PRESCALE=0, LOAD=4: expiry every 5 cycles.
    wr(4'd4, 32'd1); wr(4'd1, 32'd0); wr(4'd2, 32'd4); wr(4'd3, 32'd0);
    wr(4'd0, 32'd7);
    rd(4'd4, 32'd0);
    rd(4'd4, 32'd1);
    rd(4'd3, 32'd3);
    wr(4'd4, 32'd1);
    rd(4'd4, 32'd0);
    wr(4'd4, 32'd1);          // lands on the expiry edge
    rd(4'd4, 32'd1);
    wr(4'd3, 32'd77);         // lands on a tick
    rd(4'd3, 32'd77);
    wr(4'd0, 32'd0);

    // Asynchronous reset mid-count.
    wr(4'd1, 32'd7); wr(4'd2, 32'd0); wr(4'd3, 32'd100); wr(4'd0, 32'd5);
    idle(20);
    rd_m(4'd3);
    check("irq_before_reset", 32'(irq), 32'd1);
    en = 1'b1; wen = 1'b0; addr = 4'd3; wdata = 32'd0;
    exp_q.push_back(32'd0);
    #2 nreset = 1'b0;
    #1;
    check("count_in_reset", rdata, 32'd0);
    check("irq_in_reset", 32'(irq), 32'd0);
    @(negedge clk); #1 en = 1'b0;
    @(posedge clk); #1 nreset = 1'b1;
    idle(10);
    rd(4'd3, 32'd0);
    rd(4'd0, 32'd0);
    rd(4'd4, 32'd0);
    rd(4'd3, 32'd0);

`ifdef TIMER_PWM_EN
    wr(4'd1, 32'd0); wr(4'd2, 32'd9); wr(4'd5, 32'd3); wr(4'd3, 32'd9);
    wr(4'd0, 32'd3);
    idle(5);
    hi = 0;
    repeat (10) begin
      @(negedge clk);
      hi += int'(pwm);
    end
    @(posedge clk); #1;
    check("pwm_duty", 32'(hi), 32'd3);
    rd(4'd5, 32'd3);
    wr(4'd0, 32'd0);
`else
    hi = 0;
    wr(4'd5, 32'd3);
    rd(4'd5, 32'd0);
`endif

    // Random register traffic against the model.
    repeat (600) begin
      case ($urandom_range(0, 9))
        0, 1, 2: rd_m(4'($urandom_range(0, 15)));
        3:       wr(4'd0, $urandom);
        4:       wr(4'd2, $urandom_range(0, 6));
        5:       wr(4'd3, $urandom_range(0, 10));
        6:       wr(4'd4, $urandom);
        7:       if (!m_en) wr(4'd1, $urandom_range(0, 3)); else idle(1);
        8:       wr(4'($urandom_range(5, 15)), $urandom);
        default: idle($urandom_range(1, 4));
      endcase
    end

    idle(2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 Parameter PRESCALE_W, default 16, width of the prescaler counter and PRESCALE register.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 nreset  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  bus select; this responder is addressed when high.
REQ-005 wen  input  1  write strobe, qualified by en; en & ~wen is a read.
REQ-006 addr  input  4  register word index.
REQ-007 wdata  input  32  CPU write data.
REQ-008 rdata  output  32  read data.
REQ-009 irq  output  1  level interrupt, expired & CTRL.irq_en.
REQ-010 pwm  output  1  PWM output; tied 0 when TIMER_PWM_EN is undefined.

Function
REQ-011 Register map (addr) SHALL be:
- 0 CTRL: bit0 enable, bit1 auto_reload, bit2 irq_en; other bits read 0.
- 1 PRESCALE: R/W, PRESCALE_W bits.
- 2 LOAD: R/W, 32 bits.
- 3 COUNT: read gives the live counter; a write sets the counter and clears the prescaler.
- 4 STATUS: bit0 expired; writing 1 clears it (W1C).
- 5 COMPARE: present only with TIMER_PWM_EN.
- All other indices read 0; writes to them are ignored.
REQ-012 Writes take effect on the clk edge where en & wen is high; a write is exactly one cycle.
REQ-013 rdata SHALL be combinational from addr when en & ~wen; otherwise 32'h0, so the SOC can OR or tristate it.
REQ-014 Prescaler, when enable=1: counts 0..PRESCALE, then wraps to 0 and issues a one-cycle tick. PRESCALE=0 gives a tick every cycle.
REQ-015 On a tick with COUNT>0: COUNT decrements by 1.
REQ-016 On a tick with COUNT==0:
- expired is set.
- If auto_reload=1: COUNT<=LOAD.
- If auto_reload=0: COUNT stays 0 and CTRL.enable clears.
REQ-017 With enable=0: prescaler and COUNT hold.
REQ-018 Writing CTRL.enable from 0 to 1 clears the prescaler.
REQ-019 COUNT write in the same cycle as a tick: the write wins and the tick is discarded.
REQ-020 W1C to STATUS in the same cycle as an expiry: set wins and expired stays 1.
REQ-021 LOAD=0 with auto_reload=1 expires on every tick.
REQ-022 All arithmetic is unsigned. COUNT never wraps below 0.

Reset
REQ-023 While nreset=0, SHALL force asynchronously:
- CTRL=0, PRESCALE=0, LOAD=0, COUNT=0, COMPARE=0.
- prescaler=0, expired=0.
REQ-024 Output values during reset: irq=0, pwm=0; rdata follows REQ-013.
REQ-025 Reset asserted mid-count SHALL abort the count. After release, the timer stays idle until software sets enable.

Configuration
REQ-026 Macro TIMER_PWM_EN defined:
- COMPARE register exists at addr 5.
- pwm is registered and equals (COUNT < COMPARE) & enable.
REQ-027 Macro undefined:
- addr 5 reads 0 and writes to it are ignored.
- pwm is constant 0.
- No compare logic is synthesised.

Structure
REQ-028 Package timer_pkg SHALL hold the register index constants, the CTRL bit positions and the STATUS bit positions.
REQ-029 One sub-module, timer_prescaler (enable, clear, limit -> tick), SHALL be instantiated once.

Verification
REQ-030 Reset then read addr 0..5 -> all reads 0; irq=0; pwm=0.
REQ-031 PRESCALE=3, LOAD=2, COUNT=2, CTRL=3'b101 -> first expiry 12 cycles after enable; irq=1; enable cleared; COUNT=0.
REQ-032 CTRL=3'b111, PRESCALE=0, LOAD=4, COUNT=0:
- expired sets on the first tick.
- COUNT reloads to 4 and expires again every 5 cycles.
- W1C STATUS=1 drops irq for the next cycle.
REQ-033 W1C STATUS issued in the exact expiry cycle -> expired stays 1. COUNT write coinciding with a tick -> COUNT equals the written value.
REQ-034 nreset pulsed low mid-count with COUNT=100 -> COUNT=0, CTRL=0, irq=0 immediately without waiting for clk; the counter does not move after release.
REQ-035 (TIMER_PWM_EN) LOAD=9, COMPARE=3, auto-reload, PRESCALE=0 -> pwm high 3 of every 10 cycles.
